// File: rtl/div_share_arb.sv
// Round-robin arbiter/sequencer sharing one serial divider between NUM_REQ requesters.
// One operation in flight: grant in IDLE, issue latched operands in ISSUE, route the result in BUSY.
module div_share_arb #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic [NUM_REQ-1:0]                      req_vld_i,
    output logic [NUM_REQ-1:0]                      req_rdy_o,
    input  logic [NUM_REQ-1:0][TRANS_ID_BITS-1:0]   req_id_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]           req_op_a_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]           req_op_b_i,
    input  logic [NUM_REQ-1:0][1:0]                 req_opcode_i,
    output logic [NUM_REQ-1:0]                      rsp_vld_o,
    input  logic [NUM_REQ-1:0]                      rsp_rdy_i,
    output logic [TRANS_ID_BITS-1:0]                rsp_id_o,
    output logic [WIDTH-1:0]                        rsp_res_o,
    output logic                                    div_in_vld_o,
    input  logic                                    div_in_rdy_i,
    output logic [TRANS_ID_BITS-1:0]                div_id_o,
    output logic [WIDTH-1:0]                        div_op_a_o,
    output logic [WIDTH-1:0]                        div_op_b_o,
    output logic [1:0]                              div_opcode_o,
    output logic                                    div_flush_o,
    input  logic                                    div_out_vld_i,
    output logic                                    div_out_rdy_o,
    input  logic [TRANS_ID_BITS-1:0]                div_id_i,
    input  logic [WIDTH-1:0]                        div_res_i,
    output logic                                    id_mismatch_o
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [WIDTH-1:0]         op_a;
        logic [WIDTH-1:0]         op_b;
        logic [1:0]               opcode;
    } div_req_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d, owner_q, owner_d;
    logic [IDX_W-1:0] gnt_idx, cand;
    logic             gnt_vld, accept, mism_q;
    div_req_t         req_q;

    // Cyclic search starting at rr_q; first valid requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = IDX_W'((int'(rr_q) + k) % int'(NUM_REQ));
            if (!gnt_vld && req_vld_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        accept        = 1'b0;
        req_rdy_o     = '0;
        rsp_vld_o     = '0;
        div_in_vld_o  = 1'b0;
        div_out_rdy_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    req_rdy_o[gnt_idx] = 1'b1;
                    accept             = 1'b1;
                    owner_d            = gnt_idx;
                    rr_d               = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                div_in_vld_o = 1'b1;
                if (div_in_rdy_i) state_d = BUSY;
            end
            BUSY: begin
                rsp_vld_o[owner_q] = div_out_vld_i;
                div_out_rdy_o      = rsp_rdy_i[owner_q];
                if (div_out_vld_i && rsp_rdy_i[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush kills every handshake this cycle and leaves the pointer alone.
        if (flush_i) begin
            req_rdy_o     = '0;
            rsp_vld_o     = '0;
            div_in_vld_o  = 1'b0;
            div_out_rdy_o = 1'b0;
            accept        = 1'b0;
            rr_d          = rr_q;
            owner_d       = owner_q;
            state_d       = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            req_q   <= '0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            if (accept) begin
                req_q.id     <= req_id_i[gnt_idx];
                req_q.op_a   <= req_op_a_i[gnt_idx];
                req_q.op_b   <= req_op_b_i[gnt_idx];
                req_q.opcode <= req_opcode_i[gnt_idx];
            end
            // Sticky until reset: a result came back tagged for a different operation.
            if (state_q == BUSY && div_out_vld_i && div_id_i != req_q.id) mism_q <= 1'b1;
        end
    end

    assign div_id_o      = req_q.id;
    assign div_op_a_o    = req_q.op_a;
    assign div_op_b_o    = req_q.op_b;
    assign div_opcode_o  = req_q.opcode;
    assign div_flush_o   = flush_i;
    assign rsp_id_o      = div_id_i;
    assign rsp_res_o     = div_res_i;
    assign id_mismatch_o = mism_q;

endmodule
